// File: rtl/seg_capture_decode.sv
// -----------------------------------------------------------------------------
// seg_capture_decode
//
// Purpose:
//   Reads back a multiplexed, active-low 7-segment display bus. Each sample of
//   (segment pattern, digit enables) has to stay identical for STABLE_CYC
//   consecutive clocks before it is accepted. An accepted pattern is decoded
//   to a hex nibble. When a digit's 8-bit code differs from the last code
//   accepted for that digit, a capture event is emitted on a single-entry
//   valid/ready output buffer. An event that arrives while the buffer is full
//   and not being drained is dropped, and the sticky ovf flag is set.
//
// Parameters:
//   N_DIG       number of multiplexed digits (width of an_in)
//   STABLE_CYC  consecutive identical samples needed before an accept (>= 2)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   seg_in      segment pattern, active-low: bit7 = dp, bits6..0 = g..a
//   an_in       digit enables, active-low; exactly one low on a valid sample
//   out_valid   capture event available
//   out_ready   consumer takes the event when high together with out_valid
//   out_digit   index of the digit that changed
//   out_nibble  decoded hex value (0 for blank or undecodable patterns)
//   out_dp      decimal point lit
//   out_blank   pattern had every segment off
//   out_err     pattern is neither a hex glyph nor blank
//   digits      last accepted nibble per digit, digit i at [4i+3:4i]
//   ovf         sticky flag: an event was dropped because the buffer was full
//   clr_ovf     synchronous clear of ovf (a coincident drop wins)
// -----------------------------------------------------------------------------
module seg_capture_decode #(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 16,
  localparam int DIG_W     = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         seg_in,
  input  logic [N_DIG-1:0]   an_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIG_W-1:0]   out_digit,
  output logic [3:0]         out_nibble,
  output logic               out_dp,
  output logic               out_blank,
  output logic               out_err,
  output logic [4*N_DIG-1:0] digits,
  output logic               ovf,
  input  logic               clr_ovf
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    SETTLE,
    LOCKED
  } state_t;

  // ---------------------------------------------------------------------------
  // Input sampling. seg_s/an_s hold the current sample; seg_p/an_p hold the
  // sample before it. The reset value (all enables high) is an invalid sample,
  // so nothing can count as stable until real data has been seen.
  // ---------------------------------------------------------------------------
  logic [7:0]       seg_s_reg;
  logic [N_DIG-1:0] an_s_reg;
  logic [7:0]       seg_p_reg;
  logic [N_DIG-1:0] an_p_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s_reg <= 8'hFF;
      an_s_reg  <= '1;
      seg_p_reg <= 8'hFF;
      an_p_reg  <= '1;
    end else begin
      seg_s_reg <= seg_in;
      an_s_reg  <= an_in;
      seg_p_reg <= seg_s_reg;
      an_p_reg  <= an_s_reg;
    end
  end

  // A sample is valid when exactly one enable is low. With an_low = ~an,
  // "exactly one bit set" means nonzero, and clearing the lowest set bit
  // leaves nothing.
  logic [N_DIG-1:0] an_low;
  logic             sample_valid;
  logic             sample_same;
  logic             sample_steady;

  always_comb begin
    an_low        = ~an_s_reg;
    sample_valid  = (an_low != '0) && ((an_low & (an_low - N_DIG'(1))) == '0);
    sample_same   = (seg_s_reg == seg_p_reg) && (an_s_reg == an_p_reg);
    sample_steady = sample_valid && sample_same;
  end

  // ---------------------------------------------------------------------------
  // Stability FSM.
  // cnt counts consecutive identical valid samples, including the first one.
  // cnt is updated from the comparison of seg_s against seg_p, and seg_p
  // advances on the same edge. So when cnt equals STABLE_CYC, seg_p/an_p
  // already hold the pattern that was stable, and the accept reads them.
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic [CNT_W-1:0] cnt_reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SETTLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    // A differing or invalid sample restarts the run: a valid one is the
    // first sample of a new run, an invalid one starts no run at all.
    cnt_reload = sample_valid ? CNT_ONE : '0;

    case (state_reg)
      SETTLE: begin
        if (cnt_reg == CNT_MAX) begin
          accept = 1'b1;
          // A change that lands in the accept cycle must not be lost.
          // Without this test the FSM would enter LOCKED with the new value
          // already in the compare registers, and would never see the change.
          if (sample_steady) begin
            state_next = LOCKED;
          end else begin
            cnt_next = cnt_reload;
          end
        end else if (sample_steady) begin
          cnt_next = cnt_reg + CNT_ONE;
        end else begin
          cnt_next = cnt_reload;
        end
      end
      LOCKED: begin
        if (!sample_steady) begin
          cnt_next   = cnt_reload;
          state_next = SETTLE;
        end
      end
      default: begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Decode of the accepted pattern (dp ignored).
  // ---------------------------------------------------------------------------
  logic [3:0] dec_nib;
  logic       dec_hit;
  logic       dec_blank;
  logic       dec_err;

  always_comb begin
    dec_hit = 1'b1;
    dec_nib = 4'h0;
    case (seg_p_reg[6:0])
      7'h40:   dec_nib = 4'h0;
      7'h79:   dec_nib = 4'h1;
      7'h24:   dec_nib = 4'h2;
      7'h30:   dec_nib = 4'h3;
      7'h19:   dec_nib = 4'h4;
      7'h12:   dec_nib = 4'h5;
      7'h02:   dec_nib = 4'h6;
      7'h78:   dec_nib = 4'h7;
      7'h00:   dec_nib = 4'h8;
      7'h10:   dec_nib = 4'h9;
      7'h08:   dec_nib = 4'hA;
      7'h03:   dec_nib = 4'hB;
      7'h46:   dec_nib = 4'hC;
      7'h21:   dec_nib = 4'hD;
      7'h06:   dec_nib = 4'hE;
      7'h0E:   dec_nib = 4'hF;
      default: dec_hit = 1'b0;
    endcase
    dec_blank = (seg_p_reg[6:0] == 7'h7F);
    dec_err   = !dec_hit && !dec_blank;
  end

  // Position of the single low enable in the accepted sample. This only
  // matters while accept is high, which implies the sample was valid.
  function automatic logic [DIG_W-1:0] an_index(input logic [N_DIG-1:0] an);
    logic [DIG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (!an[i]) begin
        idx = DIG_W'(i);
      end
    end
    return idx;
  endfunction

  logic [DIG_W-1:0]          acc_dig;
  logic [N_DIG-1:0][7:0]     last_code_all;
  logic                      evt;

  always_comb begin
    acc_dig = an_index(an_p_reg);
    evt     = accept && (seg_p_reg != last_code_all[acc_dig]);
  end

  // ---------------------------------------------------------------------------
  // Per-digit state: the last accepted 8-bit code (reset to FF, which is
  // blank with dp off) and the last decodable nibble. The code changes on
  // every event, including dropped ones. The nibble changes only on a real
  // glyph, so a blank or garbage pattern leaves the last good digit visible.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_DIG; gi++) begin : g_dig
      logic [7:0] code_reg;
      logic [3:0] nib_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          code_reg <= 8'hFF;
          nib_reg  <= 4'h0;
        end else if (evt && (acc_dig == DIG_W'(gi))) begin
          code_reg <= seg_p_reg;
          if (dec_hit) begin
            nib_reg <= dec_nib;
          end
        end
      end

      assign last_code_all[gi]   = code_reg;
      assign digits[4*gi +: 4]   = nib_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Single-entry output buffer. A new event can take the slot when the slot is
  // empty or is being drained on this same edge. Otherwise the event is
  // dropped and ovf records the loss.
  // ---------------------------------------------------------------------------
  logic             out_valid_reg;
  logic [DIG_W-1:0] out_digit_reg;
  logic [3:0]       out_nibble_reg;
  logic             out_dp_reg;
  logic             out_blank_reg;
  logic             out_err_reg;
  logic             ovf_reg;
  logic             slot_free;

  assign slot_free = !out_valid_reg || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_digit_reg  <= '0;
      out_nibble_reg <= 4'h0;
      out_dp_reg     <= 1'b0;
      out_blank_reg  <= 1'b0;
      out_err_reg    <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      if (evt && slot_free) begin
        out_valid_reg  <= 1'b1;
        out_digit_reg  <= acc_dig;
        out_nibble_reg <= dec_nib;   // dec_nib is 0 whenever dec_hit is low
        out_dp_reg     <= !seg_p_reg[7];
        out_blank_reg  <= dec_blank;
        out_err_reg    <= dec_err;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg  <= 1'b0;
      end

      if (evt && !slot_free) begin
        ovf_reg <= 1'b1;
      end else if (clr_ovf) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_digit  = out_digit_reg;
  assign out_nibble = out_nibble_reg;
  assign out_dp     = out_dp_reg;
  assign out_blank  = out_blank_reg;
  assign out_err    = out_err_reg;
  assign ovf        = ovf_reg;

endmodule
